// File: rtl/instruction_loader_pkg.sv
// Shared constants and FSM encoding for the instruction loader.
package instruction_loader_pkg;

  localparam int LEN            = 32;
  localparam int BYTES_PER_WORD = LEN / 8;
  localparam logic [LEN-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/instruction_loader_byte_packer.sv
// Assembles a byte stream into words, first byte in the MSBs.
// o_word/o_word_valid are combinational so the caller can register the completed word.
module instruction_loader_byte_packer
  import instruction_loader_pkg::*;
#(
  parameter int len = LEN
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_clear,
  input  logic           i_byte_en,
  input  logic [7:0]     i_byte,
  output logic [len-1:0] o_word,
  output logic           o_word_valid
);

  localparam int BPW   = len / 8;
  localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [len-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_byte_s;

  assign last_byte_s  = (cnt_q == CNT_W'(BPW - 1));
  assign o_word       = {shift_q[len-9:0], i_byte};
  assign o_word_valid = i_byte_en && last_byte_s;

  // Shift/count next state; clear has priority so a restart drops partial words.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (i_clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (i_byte_en) begin
      shift_d = {shift_q[len-9:0], i_byte};
      cnt_d   = last_byte_s ? '0 : cnt_q + CNT_W'(1);
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  // Assembly register and byte counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Packs a received byte stream into instruction words, writes them to RAM port A
// and keeps the CPU in reset until a HALT word is stored or memory fills up.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int len       = 32,
  parameter int RAM_DEPTH = 2048,
  parameter int ADDR_W    = 11,
  parameter logic [len-1:0] HALT_WORD = instruction_loader_pkg::HALT_WORD
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [len-1:0]    o_wr_data,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_full,
  output logic [ADDR_W:0]   o_word_count
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [len-1:0]      wr_data_q, wr_data_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                full_q, full_d;

  logic                start_take_s;
  logic                byte_en_s;
  logic [len-1:0]      word_s;
  logic                word_valid_s;
  logic                last_addr_s;

  assign start_take_s = i_start && (state_q != ST_LOAD);
  assign byte_en_s    = i_rx_valid && (state_q == ST_LOAD);
  assign last_addr_s  = (addr_q == ADDR_W'(RAM_DEPTH - 1));

  instruction_loader_byte_packer #(.len(len)) u_packer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (start_take_s),
    .i_byte_en    (byte_en_s),
    .i_byte       (i_rx_data),
    .o_word       (word_s),
    .o_word_valid (word_valid_s)
  );

  // Session FSM, address/count bookkeeping and write strobe generation.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    full_d    = full_q;
    // Hold follows the registered state, so it drops the cycle after o_done rises.
    hold_d    = (state_q != ST_DONE);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d = ST_LOAD;
          addr_d  = '0;
          count_d = '0;
          done_d  = 1'b0;
          full_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (word_valid_s) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = word_s;
          count_d   = count_q + (ADDR_W+1)'(1);
          if ((word_s == HALT_WORD) || last_addr_s) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            full_d  = last_addr_s;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= 1'b1;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      full_q    <= full_d;
    end
  end

  assign o_wr_en      = wr_en_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_cpu_hold   = hold_q;
  assign o_done       = done_q;
  assign o_full       = full_q;
  assign o_word_count = count_q;

endmodule
